// File: rtl/qracc_pkg.sv
// qracc_pkg: shared SRAM request/response types and weight loader state encoding.
package qracc_pkg;
  localparam int NUM_ROWS = 128;
  localparam int NUM_COLS = 32;
  localparam int ADDR_W = $clog2(NUM_ROWS);
  localparam int LOADER_TMO_DEFAULT = 255;
  typedef struct packed {
    logic rq_valid_i;
    logic rq_wr_i;
    logic [ADDR_W-1:0] addr_i;
    logic [NUM_COLS-1:0] wr_data_i;
  } to_sram_t;
  typedef struct packed {
    logic rq_ready_o;
    logic [NUM_COLS-1:0] rd_data_o;
    logic rd_valid_o;
  } from_sram_t;
`ifdef QRACC_LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE, S_READ, S_RDWAIT} loader_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} loader_state_t;
`endif
endpackage

// File: rtl/qracc_weight_loader.sv
// qracc_weight_loader: streams weight words into the SRAM request port, one write per row.
// Define QRACC_LOADER_VERIFY_EN to add a read-back verify pass with watchdog and error reporting.
module qracc_weight_loader
  import qracc_pkg::*;
`ifdef QRACC_LOADER_VERIFY_EN
#(parameter int tmoCycles = LOADER_TMO_DEFAULT)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0] num_rows_i,
  output logic busy_o,
  output logic done_o,
  input  logic wdata_valid_i,
  output logic wdata_ready_o,
  input  logic [NUM_COLS-1:0] wdata_i,
  output to_sram_t to_sram_o,
  input  from_sram_t from_sram_i
`ifdef QRACC_LOADER_VERIFY_EN
  ,
  output logic [ADDR_W:0] err_count_o,
  output logic [ADDR_W-1:0] err_addr_o
`endif
);
  localparam logic [ADDR_W:0] ONE = 1;
  loader_state_t state, nxt;
  logic [ADDR_W-1:0] base, row_n;
  logic [ADDR_W:0] cnt, idx, idx_n;
  logic [NUM_COLS-1:0] word, word_n;
  logic acc, last, adv, req;
  assign acc = to_sram_o.rq_valid_i && from_sram_i.rq_ready_o;
  assign last = idx + ONE == cnt;
`ifdef QRACC_LOADER_VERIFY_EN
  localparam int TW = $clog2(tmoCycles + 1);
  logic [TW-1:0] wd;
  logic [ADDR_W-1:0] row;
  logic tmo, bad;
  assign row = base + idx[ADDR_W-1:0];
  assign tmo = wd == TW'(tmoCycles - 1);
  assign adv = state == S_RDWAIT && (from_sram_i.rd_valid_o || tmo);
  assign bad = state == S_RDWAIT && (from_sram_i.rd_valid_o ? from_sram_i.rd_data_o != word : tmo);
  assign req = nxt == S_WRITE || nxt == S_READ;
`else
  logic unused_rd;
  assign unused_rd = ^{from_sram_i.rd_data_o, from_sram_i.rd_valid_o};
  assign adv = state == S_WRITE && acc;
  assign req = nxt == S_WRITE;
`endif
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = !start_i ? S_IDLE : num_rows_i == '0 ? S_DONE : S_FETCH;
      S_FETCH:  nxt = wdata_valid_i ? S_WRITE : S_FETCH;
`ifdef QRACC_LOADER_VERIFY_EN
      S_WRITE:  nxt = acc ? S_READ : S_WRITE;
      S_READ:   nxt = acc ? S_RDWAIT : S_READ;
`endif
      S_DONE:   nxt = S_IDLE;
      default:  ;
    endcase
    if (adv) nxt = last ? S_DONE : S_FETCH;
  end
  assign idx_n = state == S_IDLE ? '0 : adv ? idx + ONE : idx;
  assign row_n = base + idx_n[ADDR_W-1:0];
  assign word_n = state == S_FETCH && wdata_valid_i ? wdata_i : word;
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      base <= '0;
      cnt <= '0;
      idx <= '0;
      word <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      wdata_ready_o <= 1'b0;
      to_sram_o <= '0;
    end else begin
      state <= nxt;
      idx <= idx_n;
      word <= word_n;
      if (state == S_IDLE && start_i) begin
        base <= base_addr_i;
        cnt <= num_rows_i;
      end
      busy_o <= nxt != S_IDLE;
      done_o <= nxt == S_DONE;
      wdata_ready_o <= nxt == S_FETCH;
      to_sram_o.rq_valid_i <= req;
      to_sram_o.rq_wr_i <= nxt == S_WRITE;
      to_sram_o.addr_i <= req ? row_n : '0;
      to_sram_o.wr_data_i <= nxt == S_WRITE ? word_n : '0;
    end
  end
`ifdef QRACC_LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start_i)) begin
      err_count_o <= '0;
      err_addr_o <= '0;
      wd <= '0;
    end else begin
      wd <= state == S_RDWAIT && !adv ? wd + TW'(1) : '0;
      if (bad && err_count_o != '1) err_count_o <= err_count_o + ONE;
      if (bad && err_count_o == '0) err_addr_o <= row;
    end
  end
`endif
endmodule

// File: tb/tb_qracc_weight_loader.sv
// tb_qracc_weight_loader: directed loads against a row-list model of the expected SRAM writes.
module tb_qracc_weight_loader;
  import qracc_pkg::*;
  logic clk = 0, rst = 1, start = 0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0] num = '0;
  logic busy, done, wr;
  logic wv = 0;
  logic [NUM_COLS-1:0] wd = '0;
  to_sram_t ts;
  from_sram_t fs = '0;
`ifdef QRACC_LOADER_VERIFY_EN
  logic [ADDR_W:0] ec;
  logic [ADDR_W-1:0] ea;
  int rd_reqs = 0, rd_served = 0, rd_w = 0, last_rd = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic flip = 0, no_rsp = 0;
`endif
  int vec = 0, errs = 0, cyc = 0;
  logic [31:0] wq[0:1023];
  logic [31:0] ed_q[0:1023];
  logic [6:0] ea_q[0:1023];
  logic [6:0] acc_log[0:1023];
  logic [31:0] mem[0:127];
  int w_tail = 0, taken = 0, e_tail = 0, e_head = 0;
  int acc_n = 0, last_acc = 0, done_cyc = 0, done_n = 0;
  int gap = 0, stall_n = 0, stall_used = 0, stall_seen = 0;
  logic pend = 0;
  to_sram_t held;

  qracc_weight_loader dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .num_rows_i(num),
    .busy_o(busy), .done_o(done), .wdata_valid_i(wv), .wdata_ready_o(wr), .wdata_i(wd),
    .to_sram_o(ts), .from_sram_i(fs)
`ifdef QRACC_LOADER_VERIFY_EN
    , .err_count_o(ec), .err_addr_o(ea)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus source: word stream with optional gaps, ready stalls, read responses.
  always @(posedge clk) begin
    #1;
    wv = (taken < w_tail) && ($urandom_range(99) >= 32'(gap));
    wd = (taken < w_tail) ? wq[taken] : $urandom;
    if (ts.rq_valid_i && stall_used < stall_n) begin
      fs.rq_ready_o = 1'b0;
      stall_used++;
    end else fs.rq_ready_o = 1'b1;
`ifdef QRACC_LOADER_VERIFY_EN
    fs.rd_valid_o = 1'b0;
    if (no_rsp) rd_served = rd_reqs;
    else if (rd_reqs > rd_served) begin
      if (rd_w == 2) begin
        fs.rd_valid_o = 1'b1;
        fs.rd_data_o = mem[rd_addr] ^ ((flip && rd_addr == 2) ? 32'h8 : 32'h0);
        rd_served++;
        rd_w = 0;
      end else rd_w++;
    end
`endif
  end

  // Compare process: every write must match the next expected (row, word) pair.
  always @(negedge clk) begin
    if (rst) begin
      taken = w_tail;
      e_head = e_tail;
      pend = 0;
    end else begin
      if (pend) begin
        chk("hold_stable", ts, held);
        stall_seen++;
      end
      if (wr || ts.rq_valid_i) chk("ready_only_in_fetch", wr && ts.rq_valid_i, 0);
      if (wr) chk("no_pending_word_in_fetch", taken - e_head, 0);
`ifndef QRACC_LOADER_VERIFY_EN
      if (ts.rq_valid_i) chk("rq_wr_high", ts.rq_wr_i, 1);
`endif
      if (wv && wr) taken++;
      if (ts.rq_valid_i && fs.rq_ready_o && ts.rq_wr_i) begin
        if (e_head >= e_tail) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", ts.addr_i, ea_q[e_head]);
          chk("wr_data", ts.wr_data_i, ed_q[e_head]);
          e_head++;
        end
        mem[ts.addr_i] = ts.wr_data_i;
        acc_log[acc_n] = ts.addr_i;
        acc_n++;
        last_acc = cyc;
      end
`ifdef QRACC_LOADER_VERIFY_EN
      if (ts.rq_valid_i && fs.rq_ready_o && !ts.rq_wr_i) begin
        chk("rd_addr", ts.addr_i, acc_log[acc_n-1]);
        rd_addr = ts.addr_i;
        rd_reqs++;
        last_rd = cyc;
      end
`endif
      if (done) begin
        done_cyc = cyc;
        done_n++;
      end
      pend = ts.rq_valid_i && !fs.rq_ready_o;
      held = ts;
    end
  end

  task automatic push_rows(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      wq[w_tail] = $urandom;
      ed_q[e_tail] = wq[w_tail];
      ea_q[e_tail] = 7'((b + i) % 128);
      w_tail++;
      e_tail++;
    end
  endtask

  task automatic load(input int b, input int n, input int g, output int s);
    int d0;
    gap = g;
    push_rows(b, n);
    d0 = done_n;
    @(posedge clk);
    #1;
    base = 7'(b);
    num = 8'(n);
    start = 1;
    s = cyc;
    @(posedge clk);
    #1;
    start = 0;
    for (int k = 0; k < 4000 && done_n == d0; k++) @(negedge clk);
    chk("done_seen", done_n - d0, 1);
    chk("all_rows_written", e_tail - e_head, 0);
    chk("all_words_taken", w_tail - taken, 0);
`ifndef QRACC_LOADER_VERIFY_EN
    if (n > 0) chk("done_after_last_acc", done_cyc - last_acc, 1);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int s, a0, st0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wready", wr, 0);
    chk("reset_to_sram", ts, 0);
`ifdef QRACC_LOADER_VERIFY_EN
    chk("reset_err_count", ec, 0);
    chk("reset_err_addr", ea, 0);
`endif
    a0 = acc_n;
    load(0, 4, 0, s);
    for (int i = 0; i < 4; i++) chk("t1_addr_literal", acc_log[a0+i], i);
`ifndef QRACC_LOADER_VERIFY_EN
    chk("t1_start_to_done", done_cyc - s, 9);
    chk("t1_last_accept", last_acc - s, 8);
`endif
    a0 = acc_n;
    load(127, 2, 0, s);
    chk("t2_wrap_first", acc_log[a0], 127);
    chk("t2_wrap_second", acc_log[a0+1], 0);
    a0 = acc_n;
    load(5, 0, 0, s);
    chk("t3_no_requests", acc_n - a0, 0);
    chk("t3_done_cycle1", done_cyc - s, 1);
    a0 = acc_n;
    st0 = stall_seen;
    stall_n = stall_used + 5;
    load(10, 3, 0, s);
    chk("t4_stall_cycles", stall_seen - st0, 5);
    chk("t4_accepts", acc_n - a0, 3);
    a0 = acc_n;
    load(40, 12, 60, s);
    chk("t5_gapped_accepts", acc_n - a0, 12);
    push_rows(30, 3);
    stall_n = stall_used + 1000;
    @(posedge clk);
    #1;
    base = 30;
    num = 3;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 50 && !ts.rq_valid_i; k++) @(negedge clk);
    chk("t6_reached_write", ts.rq_valid_i, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    stall_n = stall_used;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wready", wr, 0);
    chk("t6_rst_to_sram", ts, 0);
    a0 = acc_n;
    load(20, 3, 0, s);
    chk("t7_clean_restart", acc_log[a0], 20);
`ifdef QRACC_LOADER_VERIFY_EN
    flip = 1;
    load(0, 4, 0, s);
    flip = 0;
    chk("v1_err_count", ec, 1);
    chk("v1_err_addr", ea, 2);
    no_rsp = 1;
    load(9, 1, 0, s);
    no_rsp = 0;
    chk("v2_tmo_count", ec, 1);
    chk("v2_tmo_addr", ea, 9);
    chk("v2_tmo_wait", (done_cyc - last_rd) >= 255, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
